// File: rtl/inters_pkg.sv
// rtl/inters_pkg.sv - shared types and constants for the intersect stimulus generator
//
// Purpose : FSM state encoding, fault-mode constants and LFSR constants used by
//           inters_stim_gen and inters_lfsr.
// Contents: state_t, MODE_* constants, LFSR_SEED, LFSR_TAPS.

package inters_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    GAP  = 3'd4,
    FIN  = 3'd5
  } state_t;

  localparam logic [1:0] MODE_LEGAL  = 2'd0;
  localparam logic [1:0] MODE_DROP_B = 2'd1;
  localparam logic [1:0] MODE_DROP_C = 2'd2;
  localparam logic [1:0] MODE_DROP_D = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/inters_lfsr.sv
// rtl/inters_lfsr.sv - 16-bit Fibonacci LFSR for randomised gap lengths
//
// Purpose : Free-standing pseudo-random source that steps once per enable.
// Ports   : clk_i   - rising-edge clock
//           rst_ni  - asynchronous active-low reset, loads LFSR_SEED
//           en_i    - advance one step this cycle
//           state_o - current 16-bit LFSR contents

module inters_lfsr
  import inters_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  assign fb     = ^(lfsr_q & LFSR_TAPS);
  assign lfsr_d = en_i ? {lfsr_q[14:0], fb} : lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/inters_stim_gen.sv
// rtl/inters_stim_gen.sv - stimulus generator for the intersect-property checker
//
// Purpose : Emits a programmable number of e/a/b/c/d/f transactions, each legal
//           or with one sequence bit dropped, separated by idle gaps.
// Macro   : INTERS_STIM_LFSR_EN - when defined, each gap length is drawn from
//           inters_lfsr masked by the latched gap value.
// Ports   : clk, rst_n          - clock, asynchronous active-low reset
//           start               - run request, ignored unless idle
//           mode, count, gap    - fault select, transaction count, idle gap
//           a, b, c, d, e, f    - sequence / trigger / fault-tag outputs
//           busy, done          - run in progress, end-of-run pulse
//           txn_cnt             - completed transactions in current/last run

module inters_stim_gen
  import inters_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  output logic             f,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] txn_cnt
);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0] gap_len;
  logic             accept;
  logic             last_txn;

  logic a_q, b_q, c_q, d_q, e_q, f_q, busy_q, done_q;
  logic a_d, b_d, c_d, d_d, e_d, f_d, busy_d, done_d;

  assign accept   = (state_q == IDLE) && start;
  assign last_txn = (txn_cnt_q + CNT_W'(1)) == count_q;

`ifdef INTERS_STIM_LFSR_EN
  logic [15:0] lfsr_state;
  logic        lfsr_en;

  // One draw per inter-transaction gap decision; a drawn length of zero
  // degenerates to back-to-back.
  assign lfsr_en = (state_q == P2) && !last_txn && (gap_q != '0);

  inters_lfsr u_lfsr (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (lfsr_en),
    .state_o (lfsr_state)
  );

  assign gap_len = lfsr_state[GAP_W-1:0] & gap_q;
`else
  assign gap_len = gap_q;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (count != '0) ? P0 : FIN;
        end
      end
      P0: state_d = P1;
      P1: state_d = P2;
      P2: begin
        if (last_txn) begin
          state_d = FIN;
        end else if (gap_len == '0) begin
          state_d = P0;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = P0;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Run parameters and counters
  always_comb begin
    mode_d    = mode_q;
    count_d   = count_q;
    gap_d     = gap_q;
    txn_cnt_d = txn_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (accept) begin
      mode_d    = mode;
      count_d   = count;
      gap_d     = gap;
      txn_cnt_d = '0;
    end
    if (state_q == P2) begin
      txn_cnt_d = txn_cnt_q + CNT_W'(1);
      // Counter holds remaining cycles after the current one, so a gap of
      // length L loads L-1 and exits when it reads zero.
      gap_cnt_d = gap_len - GAP_W'(1);
    end
    if ((state_q == GAP) && (gap_cnt_q != '0)) begin
      gap_cnt_d = gap_cnt_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_LEGAL;
      count_q   <= '0;
      gap_q     <= '0;
      txn_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      mode_q    <= mode_d;
      count_q   <= count_d;
      gap_q     <= gap_d;
      txn_cnt_q <= txn_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Output decode from the next state so every output is a flop that lines
  // up with the state it describes.
  always_comb begin
    e_d    = (state_d == P0);
    a_d    = (state_d == P0);
    b_d    = (state_d == P1) && (mode_d != MODE_DROP_B);
    c_d    = (state_d == P1) && (mode_d != MODE_DROP_C);
    d_d    = (state_d == P2) && (mode_d != MODE_DROP_D);
    f_d    = ((state_d == P0) || (state_d == P1) || (state_d == P2)) &&
             (mode_d != MODE_LEGAL);
    busy_d = (state_d == P0) || (state_d == P1) || (state_d == P2) ||
             (state_d == GAP);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      c_q    <= 1'b0;
      d_q    <= 1'b0;
      e_q    <= 1'b0;
      f_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      d_q    <= d_d;
      e_q    <= e_d;
      f_q    <= f_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign c       = c_q;
  assign d       = d_q;
  assign e       = e_q;
  assign f       = f_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_inters_stim_gen.sv
// tb/tb_inters_stim_gen.sv - self-checking bench for inters_stim_gen

module tb_inters_stim_gen;

  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode  = 2'd0;
  logic [CNT_W-1:0] count = '0;
  logic [GAP_W-1:0] gap   = '0;
  logic             a, b, c, d, e, f, busy, done;
  logic [CNT_W-1:0] txn_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Expected per-cycle {e,a,b,c,d,f,busy,done,txn_cnt}
  logic [15:0] exp_q[$];
  logic [15:0] lfsr_m = 16'hACE1;

  // Observed downstream property: e |-> ##1 (b && c) ##1 d
  int   prop_fail = 0;
  logic e_d1 = 1'b0, e_d2 = 1'b0, bc_d1 = 1'b0;

  always #5 clk = ~clk;

  inters_stim_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .count   (count),
    .gap     (gap),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .e       (e),
    .f       (f),
    .busy    (busy),
    .done    (done),
    .txn_cnt (txn_cnt)
  );

  always @(negedge clk) begin
    if (e_d1 && !(b && c)) prop_fail <= prop_fail + 1;
    else if (e_d2 && bc_d1 && !d) prop_fail <= prop_fail + 1;
    e_d2  <= e_d1;
    e_d1  <= e;
    bc_d1 <= b && c;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] vec(input logic ee, aa, bb, cc, dd, ff, bs, dn,
                                      input logic [7:0] cn);
    return {ee, aa, bb, cc, dd, ff, bs, dn, cn};
  endfunction

  function automatic int draw_gap(input logic [3:0] gp);
`ifdef INTERS_STIM_LFSR_EN
    int l;
    l = int'(lfsr_m[3:0] & gp);
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    return l;
`else
    return int'(gp);
`endif
  endfunction

  task automatic push_run(input logic [1:0] m, input logic [7:0] cnt, input logic [3:0] gp);
    int l;
    logic fl;
    fl = (m != 2'd0);
    if (cnt == 8'd0) begin
      exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 1, 8'd0));
      exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 8'd0));
    end else begin
      for (int t = 0; t < int'(cnt); t++) begin
        exp_q.push_back(vec(1, 1, 0, 0, 0, fl, 1, 0, 8'(t)));
        exp_q.push_back(vec(0, 0, m != 2'd1, m != 2'd2, 0, fl, 1, 0, 8'(t)));
        exp_q.push_back(vec(0, 0, 0, 0, m != 2'd3, fl, 1, 0, 8'(t)));
        if (t < int'(cnt) - 1 && gp != 4'd0) begin
          l = draw_gap(gp);
          for (int j = 0; j < l; j++)
            exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 1, 0, 8'(t + 1)));
        end
      end
      exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 1, cnt));
      exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, cnt));
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run_check(input string name, input logic [1:0] m, input logic [7:0] cnt,
                           input logic [3:0] gp, input int inj, input bit inj_fin,
                           input int abort_at);
    int n;
    logic [15:0] obs, ex;
    exp_q.delete();
    push_run(m, cnt, gp);
    n = exp_q.size();
    mode  = m;
    count = cnt;
    gap   = gp;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ex  = exp_q.pop_front();
      obs = {e, a, b, c, d, f, busy, done, txn_cnt};
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i, obs, ex);
      end
      if (i == inj || (inj_fin && i == n - 2)) begin
        start = 1'b1;
        mode  = ~m;
        count = 8'd7;
        gap   = 4'd0;
      end else begin
        start = 1'b0;
      end
      if (i == abort_at) break;
    end
    start = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++;
    if ({e, a, b, c, d, f, busy, done, txn_cnt} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected 0000", {e, a, b, c, d, f, busy, done, txn_cnt});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_legal_basic;
    int p0;
    repeat (2) @(negedge clk);
    p0 = prop_fail;
    run_check("legal_basic", 2'd0, 8'd1, 4'd0, -1, 1'b0, -1);
    vectors++;
    if (prop_fail - p0 !== 0) begin
      miscompares++;
      $display("FAIL legal_basic_prop: got %0d property failures expected 0", prop_fail - p0);
    end
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = prop_fail;
    run_check("back_to_back", 2'd0, 8'd3, 4'd0, -1, 1'b0, -1);
    vectors++;
    if (prop_fail - p0 !== 0) begin
      miscompares++;
      $display("FAIL back_to_back_prop: got %0d property failures expected 0", prop_fail - p0);
    end
  endtask

  task automatic test_fault;
    int p0;
    for (int m = 1; m <= 3; m++) begin
      p0 = prop_fail;
      run_check("fault", 2'(m), 8'd2, 4'd2, -1, 1'b0, -1);
      vectors++;
      if (prop_fail - p0 !== 2) begin
        miscompares++;
        $display("FAIL fault_prop mode %0d: got %0d property failures expected 2", m, prop_fail - p0);
      end
    end
  endtask

  task automatic test_zero_and_ignored;
    run_check("zero_count", 2'd0, 8'd0, 4'd0, -1, 1'b0, -1);
    run_check("ignored_start", 2'd1, 8'd4, 4'd1, 2, 1'b1, -1);
    vectors++;
    if (txn_cnt !== 8'd4) begin
      miscompares++;
      $display("FAIL ignored_txn_cnt: got %0d expected 4", txn_cnt);
    end
  endtask

  task automatic test_reset_mid_run;
    // Index 5 is P1 of the second transaction (gap of one cycle at index 3).
    run_check("pre_reset", 2'd0, 8'd3, 4'd1, -1, 1'b0, 5);
    rst_n  = 1'b0;
    lfsr_m = 16'hACE1;
    #1;
    vectors++;
    if ({e, a, b, c, d, f, busy, done, txn_cnt} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected 0000", {e, a, b, c, d, f, busy, done, txn_cnt});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if ({e, a, b, c, d, f, busy, done, txn_cnt} !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_hold %0d: got %h expected 0000", i, {e, a, b, c, d, f, busy, done, txn_cnt});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_check("post_reset", 2'd2, 8'd2, 4'd0, -1, 1'b0, -1);
  endtask

`ifdef INTERS_STIM_LFSR_EN
  task automatic test_lfsr;
    run_check("lfsr_gaps", 2'd0, 8'd8, 4'hF, -1, 1'b0, -1);
  endtask
`endif

  initial begin
    test_reset;
    test_legal_basic;
    test_back_to_back;
    test_fault;
    test_zero_and_ignored;
    test_reset_mid_run;
`ifdef INTERS_STIM_LFSR_EN
    test_lfsr;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
